// File: rtl/out_pkg.sv
// out_pkg: shared types and default parameters for the output-stage controller.
//   out_state_t : controller state (IDLE = buffer empty, SEND = streaming lanes)
//   DEF_*       : default geometry and rounding shift used by out_ctl and its bench
package out_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } out_state_t;

  localparam int DEF_LANES = 16;
  localparam int DEF_AW    = 32;
  localparam int DEF_DW    = 16;
  localparam int DEF_SHIFT = 8;

endpackage

// File: rtl/out_ctl_sat_round.sv
// sat_round: combinational single-lane converter.
// Adds half an LSB of the shifted result (round-half-up), arithmetic-shifts right
// by SHIFT and clips to the signed DW range. The add is done at AW+1 bits so the
// largest positive accumulator cannot wrap negative before the clip.
// Ports:
//   a : signed accumulator lane, AW bits
//   y : rounded, saturated output word, DW bits
module sat_round #(
  parameter int AW    = 32,
  parameter int DW    = 16,
  parameter int SHIFT = 8
) (
  input  logic [AW-1:0] a,
  output logic [DW-1:0] y
);

  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [AW:0] RND = (SHIFT > 0) ? ((AW+1)'(1) << RSH) : '0;
  // Clip bounds expressed at AW+1 bits: 2^(DW-1)-1 and -2^(DW-1).
  localparam logic signed [AW:0] MAXV = {{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW:0] MINV = {{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}};

  logic signed [AW:0] t;
  logic signed [AW:0] sh;

  always_comb begin
    t  = $signed({a[AW-1], a}) + $signed(RND);
    sh = t >>> SHIFT;
    if (sh > MAXV) begin
      y = MAXV[DW-1:0];
    end else if (sh < MINV) begin
      y = MINV[DW-1:0];
    end else begin
      y = sh[DW-1:0];
    end
  end

endmodule

// File: rtl/out_ctl.sv
// out_ctl: output-stage controller behind the GEMM execution controller.
// On k_fin it converts every accumulator lane (round + saturate) into a
// LANES x DW buffer and streams the lanes out, one per beat.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   s_init     : slice start, clears ovf (a simultaneous drop still sets it)
//   k_fin, acc : kernel finish pulse and the accumulator vector valid with it
//   out_busy   : buffer occupied (stall the next kernel)
//   outrf      : one-cycle pulse after the last beat drains the buffer
//   ovf        : sticky, a k_fin arrived while the buffer could not take it
//   m_valid/m_ready/m_data/m_idx/m_last : output stream
//   dbg_state  : current controller state
//
// Stream handshake: a beat transfers on a rising edge where m_valid and m_ready
// are both 1. Once m_valid is raised it stays high and m_data/m_idx/m_last stay
// unchanged until that transfer. m_ready while m_valid is low is ignored, and
// m_valid never depends on m_ready.
module out_ctl
  import out_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_init,
  input  logic                     k_fin,
  input  logic [LANES*AW-1:0]      acc,
  output logic                     out_busy,
  output logic                     outrf,
  output logic                     ovf,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DW-1:0]            m_data,
  output logic [$clog2(LANES)-1:0] m_idx,
  output logic                     m_last,
  output out_state_t               dbg_state
);

  localparam int IW = $clog2(LANES);
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);

  out_state_t    state;
  logic [IW-1:0] idx;
  logic [DW-1:0] buf_q [LANES];
  logic [DW-1:0] conv  [LANES];

  logic at_last;
  logic hs;
  logic last_hs;
  logic capture;
  logic drop;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sat_round #(
      .AW    (AW),
      .DW    (DW),
      .SHIFT (SHIFT)
    ) u_sat_round (
      .a (acc[g*AW +: AW]),
      .y (conv[g])
    );
  end

  assign at_last = (idx == LAST);
  assign hs      = (state == SEND) && m_ready;
  assign last_hs = hs && at_last;
  // The buffer can take a new vector when empty, or in the very cycle its
  // last beat leaves; anything else would overwrite lanes still in flight.
  assign capture = k_fin && ((state == IDLE) || last_hs);
  assign drop    = k_fin && (state == SEND) && !last_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      outrf <= 1'b0;
      ovf   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      outrf <= 1'b0;

      if (drop) begin
        ovf <= 1'b1;
      end else if (s_init) begin
        ovf <= 1'b0;
      end

      if (capture) begin
        for (int i = 0; i < LANES; i++) begin
          buf_q[i] <= conv[i];
        end
      end

      case (state)
        IDLE: begin
          if (k_fin) begin
            state <= SEND;
            idx   <= '0;
          end
        end
        SEND: begin
          if (hs) begin
            if (!at_last) begin
              idx <= idx + 1'b1;
            end else if (k_fin) begin
              idx <= '0;
            end else begin
              state <= IDLE;
              idx   <= '0;
              outrf <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  assign m_valid   = (state == SEND);
  assign out_busy  = (state == SEND);
  assign m_idx     = idx;
  assign m_last    = (state == SEND) && at_last;
  assign m_data    = buf_q[idx];
  assign dbg_state = state;

endmodule
